// File: rtl/cache_miss_ctrl.sv
// cache_miss_ctrl
// Miss and write-through controller between the direct-mapped data cache and
// main data memory. Read misses run a single valid/ready read transaction and
// return the word to the cache as a one-cycle fill. Stores are posted into a
// small write-through FIFO that drains opportunistically while the pipeline
// keeps running. A read miss first waits for the FIFO to drain, so a read
// never overtakes a posted write.
//
// Memory port: at most one transaction is outstanding. A write request is the
// FIFO head, and it stays stable until it is popped. A read request uses the
// latched miss address.

module cache_miss_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int WBUF_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    // pipeline request side
    input  logic                  req_valid,
    input  logic                  req_wen,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic                  hit,
    output logic                  stall,
    // cache fill side
    output logic                  fill_valid,
    output logic [ADDR_WIDTH-1:0] fill_addr,
    output logic [DATA_WIDTH-1:0] fill_data,
    // memory side
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int PTR_W = $clog2(WBUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(WBUF_DEPTH);
    localparam logic [CNT_W-1:0] EMPTY_CNT = '0;
    localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);
    localparam logic [PTR_W-1:0] ONE_PTR   = PTR_W'(1);

    // controller states
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_DRAIN   = 3'd1;
    localparam logic [2:0] S_RD_REQ  = 3'd2;
    localparam logic [2:0] S_RD_WAIT = 3'd3;
    localparam logic [2:0] S_FILL    = 3'd4;

    logic [2:0]            state;
    logic [2:0]            state_nxt;

    // write-through FIFO storage and bookkeeping
    logic [ADDR_WIDTH-1:0] wb_addr [WBUF_DEPTH];
    logic [DATA_WIDTH-1:0] wb_data [WBUF_DEPTH];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      count_nxt;

    // miss context
    logic [ADDR_WIDTH-1:0] miss_addr;
    logic [DATA_WIDTH-1:0] fill_q;

    // request decode
    logic                  in_idle;
    logic                  buf_empty;
    logic                  buf_full;
    logic                  load_miss;
    logic                  store_req;
    logic                  drain_active;
    logic                  push;
    logic                  pop;
    logic                  latch_miss;

    // Decode the request and FIFO conditions; fullness uses start-of-cycle count
    always_comb begin
        in_idle      = (state == S_IDLE);
        buf_empty    = (count == EMPTY_CNT);
        buf_full     = (count == FULL_CNT);
        load_miss    = req_valid && !req_wen && !hit;
        store_req    = req_valid && req_wen;
        drain_active = (in_idle || (state == S_DRAIN)) && !buf_empty;
        push         = in_idle && store_req && !buf_full;
        pop          = drain_active && mem_ready;
        latch_miss   = in_idle && load_miss;
    end

    // Next FIFO occupancy; a simultaneous push and pop leaves it unchanged
    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + ONE_CNT;
            2'b01:   count_nxt = count - ONE_CNT;
            default: count_nxt = count;
        endcase
    end

    // Next-state logic for the miss sequence
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (load_miss) begin
                    state_nxt = buf_empty ? S_RD_REQ : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (count_nxt == EMPTY_CNT) begin
                    state_nxt = S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                if (mem_ready) begin
                    state_nxt = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (mem_rvalid) begin
                    state_nxt = S_FILL;
                end
            end
            S_FILL: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FIFO pointers and count; a reset discards every buffered store
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + ONE_PTR;
            end
            if (pop) begin
                head <= head + ONE_PTR;
            end
            count <= count_nxt;
        end
    end

    // FIFO storage; entries are only meaningful between push and pop
    always_ff @(posedge clk) begin
        if (push) begin
            wb_addr[tail] <= req_addr;
            wb_data[tail] <= req_wdata;
        end
    end

    // Hold the miss address for the whole miss, regardless of input changes
    always_ff @(posedge clk) begin
        if (rst) begin
            miss_addr <= '0;
        end else if (latch_miss) begin
            miss_addr <= req_addr;
        end
    end

    // Capture read data only while waiting for it; stray rvalid is ignored
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_q <= '0;
        end else if ((state == S_RD_WAIT) && mem_rvalid) begin
            fill_q <= mem_rdata;
        end
    end

    // Output decode; reset forces every output low in the reset cycle
    always_comb begin
        stall      = 1'b0;
        fill_valid = 1'b0;
        fill_addr  = miss_addr;
        fill_data  = fill_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;

        case (state)
            S_IDLE:    stall = load_miss || (store_req && buf_full);
            S_DRAIN:   stall = 1'b1;
            S_RD_REQ:  stall = 1'b1;
            S_RD_WAIT: stall = 1'b1;
            S_FILL:    fill_valid = 1'b1;
            default:   stall = 1'b0;
        endcase

        if (drain_active) begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = wb_addr[head];
            mem_wdata = wb_data[head];
        end else if (state == S_RD_REQ) begin
            mem_req  = 1'b1;
            mem_addr = miss_addr;
        end

        if (rst) begin
            stall      = 1'b0;
            fill_valid = 1'b0;
            fill_addr  = '0;
            fill_data  = '0;
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            mem_addr   = '0;
            mem_wdata  = '0;
        end
    end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Testbench for cache_miss_ctrl: per-cycle directed vector table plus
// hand-written multi-cycle sequences for miss latency and full-buffer stall.

module tb_cache_miss_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        hit;
    logic        stall;
    logic        fill_valid;
    logic [31:0] fill_addr;
    logic [31:0] fill_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    cache_miss_ctrl #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .WBUF_DEPTH(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_wen   (req_wen),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .hit       (hit),
        .stall     (stall),
        .fill_valid(fill_valid),
        .fill_addr (fill_addr),
        .fill_data (fill_data),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rv;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        hit;
        logic        rdy;
        logic        rvl;
        logic [31:0] rdata;
        logic        e_stall;
        logic        e_fv;
        logic [31:0] e_faddr;
        logic [31:0] e_fdata;
        logic        e_mreq;
        logic        e_mwe;
        logic [31:0] e_maddr;
        logic [31:0] e_mwdata;
    } vec_t;

    vec_t        vecs[$];
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    // expected persistent fill_addr / fill_data, updated by hand between rows
    logic [31:0] fa = '0;
    logic [31:0] fd = '0;

    task automatic add(input logic r, input logic rv, input logic wen,
                       input logic [31:0] a, input logic [31:0] wd, input logic h,
                       input logic rdy, input logic rvl, input logic [31:0] rd,
                       input logic es, input logic efv, input logic emr,
                       input logic emw, input logic [31:0] ema, input logic [31:0] emd);
        vec_t v;
        v.rst = r;  v.rv = rv;  v.wen = wen; v.addr = a; v.wdata = wd; v.hit = h;
        v.rdy = rdy; v.rvl = rvl; v.rdata = rd;
        v.e_stall = es; v.e_fv = efv; v.e_faddr = fa; v.e_fdata = fd;
        v.e_mreq = emr; v.e_mwe = emw; v.e_maddr = ema; v.e_mwdata = emd;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [131:0] act, input logic [131:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic rv, input logic wen,
                         input logic [31:0] a, input logic [31:0] wd, input logic h,
                         input logic rdy, input logic rvl, input logic [31:0] rd);
        rst = r; req_valid = rv; req_wen = wen; req_addr = a; req_wdata = wd;
        hit = h; mem_ready = rdy; mem_rvalid = rvl; mem_rdata = rd;
    endtask

    // Load miss with mem_ready tied high and rvalid lat cycles after acceptance
    task automatic miss_latency(input logic [31:0] a, input int unsigned lat,
                                input logic [31:0] d);
        int unsigned stalls = 0;
        bit          seen   = 0;
        for (int unsigned c = 0; c < 40 && !seen; c++) begin
            drive(0, 1, 0, a, '0, 0, 1, (c == lat + 1), (c == lat + 1) ? d : '0);
            @(negedge clk);
            if (fill_valid) begin
                seen = 1;
                chk("lat_fill_addr", 132'(fill_addr), 132'(a));
                chk("lat_fill_data", 132'(fill_data), 132'(d));
                chk("lat_fill_stall", 132'(stall), 132'(0));
            end else if (stall) begin
                stalls++;
            end
            @(posedge clk); #1;
        end
        chk("lat_fill_seen", 132'(seen), 132'(1));
        chk("lat_stall_cycles", 132'(stalls), 132'(lat + 2));
        drive(0, 0, 0, '0, '0, 0, 0, 0, '0);
        @(posedge clk); #1;
    endtask

    // Fill the buffer with mem_ready low, hold a fifth store, pulse ready after k cycles
    task automatic full_stall(input int unsigned k);
        int unsigned stalls = 0;
        int unsigned pops   = 0;
        bit          pushed = 0;
        logic [31:0] last_a = '0;
        logic [31:0] last_d = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            drive(0, 1, 1, 32'h400 + 4 * i, 32'hB00 + i, 0, 0, 0, '0);
            @(negedge clk);
            chk("full_fill_stall", 132'(stall), 132'(0));
            @(posedge clk); #1;
        end
        for (int unsigned c = 0; c < 20 && !pushed; c++) begin
            drive(0, 1, 1, 32'h410, 32'hB04, 0, (c == k), 0, '0);
            @(negedge clk);
            if (stall) stalls++;
            else pushed = 1;
            @(posedge clk); #1;
        end
        chk("full_pushed", 132'(pushed), 132'(1));
        chk("full_stall_cycles", 132'(stalls), 132'(k + 1));
        for (int unsigned c = 0; c < 20; c++) begin
            drive(0, 0, 0, '0, '0, 0, 1, 0, '0);
            @(negedge clk);
            if (mem_req) begin
                pops++;
                last_a = mem_addr;
                last_d = mem_wdata;
            end
            @(posedge clk); #1;
        end
        // the first of the four was already popped by the ready pulse
        chk("full_drain_pops", 132'(pops), 132'(4));
        chk("full_last_write", 132'({last_a, last_d}), 132'({32'h410, 32'hB04}));
    endtask

    initial begin
        drive(1, 0, 0, '0, '0, 0, 0, 0, '0);

        // reset, and reset with miss-looking inputs: outputs forced low
        add(1, 0,0,32'h0,  32'h0, 0, 0,0,32'h0, 0,0,0,0,32'h0,32'h0);
        add(1, 1,0,32'h80, 32'h0, 0, 1,0,32'h0, 0,0,0,0,32'h0,32'h0);
        add(0, 0,0,32'h0,  32'h0, 0, 0,0,32'h0, 0,0,0,0,32'h0,32'h0);
        // load hits
        for (int i = 0; i < 3; i++)
            add(0, 1,0,32'h40, 32'h0, 1, 0,0,32'h0, 0,0,0,0,32'h0,32'h0);
        // load miss 0x100, L=3, req_addr changed during the miss
        add(0, 1,0,32'h100,32'h0, 0, 1,0,32'h0, 1,0,0,0,32'h0,32'h0);
        fa = 32'h100;
        add(0, 1,0,32'h200,32'h0, 0, 1,0,32'h0, 1,0,1,0,32'h100,32'h0);
        add(0, 1,0,32'h200,32'h0, 0, 1,0,32'h0, 1,0,0,0,32'h0,32'h0);
        add(0, 1,0,32'h200,32'h0, 0, 1,0,32'h0, 1,0,0,0,32'h0,32'h0);
        add(0, 1,0,32'h200,32'h0, 0, 1,1,32'hDEADBEEF, 1,0,0,0,32'h0,32'h0);
        fd = 32'hDEADBEEF;
        // FILL: a store presented now is ignored
        add(0, 1,1,32'h300,32'h33, 0, 1,0,32'h0, 0,1,0,0,32'h0,32'h0);
        // stray rvalid in IDLE is ignored; nothing was pushed
        add(0, 0,0,32'h0,  32'h0, 0, 1,1,32'h12345678, 0,0,0,0,32'h0,32'h0);
        // two stores then load miss 0x18: writes drain in order before the read
        add(0, 1,1,32'h10, 32'h1, 0, 1,0,32'h0, 0,0,0,0,32'h0,32'h0);
        add(0, 1,1,32'h14, 32'h2, 0, 1,0,32'h0, 0,0,1,1,32'h10,32'h1);
        add(0, 1,0,32'h18, 32'h0, 0, 1,0,32'h0, 1,0,1,1,32'h14,32'h2);
        fa = 32'h18;
        add(0, 1,0,32'h18, 32'h0, 0, 1,0,32'h0, 1,0,0,0,32'h0,32'h0);
        add(0, 1,0,32'h18, 32'h0, 0, 1,0,32'h0, 1,0,1,0,32'h18,32'h0);
        add(0, 1,0,32'h18, 32'h0, 0, 1,1,32'hCAFE0018, 1,0,0,0,32'h0,32'h0);
        fd = 32'hCAFE0018;
        add(0, 0,0,32'h0,  32'h0, 0, 1,0,32'h0, 0,1,0,0,32'h0,32'h0);
        // five stores with mem_ready low
        add(0, 1,1,32'h20, 32'hA0, 0, 0,0,32'h0, 0,0,0,0,32'h0,32'h0);
        add(0, 1,1,32'h24, 32'hA1, 0, 0,0,32'h0, 0,0,1,1,32'h20,32'hA0);
        add(0, 1,1,32'h28, 32'hA2, 0, 0,0,32'h0, 0,0,1,1,32'h20,32'hA0);
        add(0, 1,1,32'h2C, 32'hA3, 0, 0,0,32'h0, 0,0,1,1,32'h20,32'hA0);
        add(0, 1,1,32'h30, 32'hA4, 0, 0,0,32'h0, 1,0,1,1,32'h20,32'hA0);
        add(0, 1,1,32'h30, 32'hA4, 0, 1,0,32'h0, 1,0,1,1,32'h20,32'hA0);
        add(0, 1,1,32'h30, 32'hA4, 0, 0,0,32'h0, 0,0,1,1,32'h24,32'hA1);
        add(0, 0,0,32'h0,  32'h0,  0, 1,0,32'h0, 0,0,1,1,32'h24,32'hA1);
        add(0, 0,0,32'h0,  32'h0,  0, 1,0,32'h0, 0,0,1,1,32'h28,32'hA2);
        add(0, 0,0,32'h0,  32'h0,  0, 1,0,32'h0, 0,0,1,1,32'h2C,32'hA3);
        add(0, 0,0,32'h0,  32'h0,  0, 1,0,32'h0, 0,0,1,1,32'h30,32'hA4);
        add(0, 0,0,32'h0,  32'h0,  0, 1,0,32'h0, 0,0,0,0,32'h0,32'h0);
        // mem_ready low for 4 cycles in RD_REQ
        add(0, 1,0,32'h44, 32'h0, 0, 0,0,32'h0, 1,0,0,0,32'h0,32'h0);
        fa = 32'h44;
        for (int i = 0; i < 4; i++)
            add(0, 1,0,32'h90 + 32'(i), 32'h0, 0, 0,0,32'h0, 1,0,1,0,32'h44,32'h0);
        add(0, 1,0,32'h44, 32'h0, 0, 1,0,32'h0, 1,0,1,0,32'h44,32'h0);
        add(0, 1,0,32'h44, 32'h0, 0, 1,1,32'h5555AAAA, 1,0,0,0,32'h0,32'h0);
        fd = 32'h5555AAAA;
        add(0, 0,0,32'h0,  32'h0, 0, 0,0,32'h0, 0,1,0,0,32'h0,32'h0);
        add(0, 0,0,32'h0,  32'h0, 0, 0,0,32'h0, 0,0,0,0,32'h0,32'h0);
        // reset discards buffered stores
        add(0, 1,1,32'h50, 32'hB0, 0, 0,0,32'h0, 0,0,0,0,32'h0,32'h0);
        add(0, 1,1,32'h54, 32'hB1, 0, 0,0,32'h0, 0,0,1,1,32'h50,32'hB0);
        fa = '0; fd = '0;
        add(1, 0,0,32'h0,  32'h0, 0, 0,0,32'h0, 0,0,0,0,32'h0,32'h0);
        add(0, 0,0,32'h0,  32'h0, 0, 1,0,32'h0, 0,0,0,0,32'h0,32'h0);
        // reset in RD_WAIT, later rvalid ignored
        add(0, 1,0,32'h60, 32'h0, 0, 1,0,32'h0, 1,0,0,0,32'h0,32'h0);
        fa = 32'h60;
        add(0, 1,0,32'h60, 32'h0, 0, 1,0,32'h0, 1,0,1,0,32'h60,32'h0);
        add(0, 1,0,32'h60, 32'h0, 0, 1,0,32'h0, 1,0,0,0,32'h0,32'h0);
        fa = '0;
        add(1, 0,0,32'h0,  32'h0, 0, 0,0,32'h0, 0,0,0,0,32'h0,32'h0);
        add(0, 0,0,32'h0,  32'h0, 0, 1,1,32'h77777777, 0,0,0,0,32'h0,32'h0);
        add(0, 0,0,32'h0,  32'h0, 0, 1,0,32'h0, 0,0,0,0,32'h0,32'h0);
        add(0, 1,0,32'h64, 32'h0, 1, 1,0,32'h0, 0,0,0,0,32'h0,32'h0);

        @(posedge clk); #1;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].rv, vecs[i].wen, vecs[i].addr, vecs[i].wdata,
                  vecs[i].hit, vecs[i].rdy, vecs[i].rvl, vecs[i].rdata);
            @(negedge clk);
            chk($sformatf("vec%0d", i),
                {stall, fill_valid, fill_addr, fill_data, mem_req, mem_we, mem_addr, mem_wdata},
                {vecs[i].e_stall, vecs[i].e_fv, vecs[i].e_faddr, vecs[i].e_fdata,
                 vecs[i].e_mreq, vecs[i].e_mwe, vecs[i].e_maddr, vecs[i].e_mwdata});
            @(posedge clk); #1;
        end

        miss_latency(32'h100, 3, 32'hDEADBEEF);
        miss_latency(32'h204, 1, 32'h0BADF00D);
        miss_latency(32'h208, 6, 32'h13579BDF);
        full_stall(0);
        full_stall(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
